// File: rtl/irq_pkg.sv
// Shared types, default sizing and the lowest-index priority function used by
// the interrupt controller family.
package irq_pkg;

    localparam int unsigned N_CHAN_DEF = 27;
    localparam int unsigned ID_W_DEF   = $clog2(N_CHAN_DEF);
    localparam int unsigned MAX_CHAN   = 64;
    localparam int unsigned MAX_ID_W   = 6;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVICE
    } irq_state_e;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } prio_t;

    // Lowest set index of vec; found=0 and idx=0 when vec is empty.
    function automatic prio_t prio_enc(input logic [MAX_CHAN-1:0] vec);
        prio_t res;
        res = '0;
        for (int unsigned i = 0; i < MAX_CHAN; i++) begin
            if (vec[i] && !res.found) begin
                res.found = 1'b1;
                res.idx   = MAX_ID_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Parametrised combinational lowest-index encoder; index 0 has top priority.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned N    = N_CHAN_DEF,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_vec,
    output logic            o_found,
    output logic [ID_W-1:0] o_idx
);

    prio_t w_res;

    assign w_res   = prio_enc(MAX_CHAN'(i_vec));
    assign o_found = w_res.found;
    assign o_idx   = ID_W'(w_res.idx);

endmodule

// File: rtl/irq_prio_ctrl.sv
// Registered priority interrupt controller: per-channel edge/level capture
// into a pending register, mask register, fixed-priority selection and a
// valid/ready grant with an in-service lock released by EOI.
module irq_prio_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned       N_CHAN    = N_CHAN_DEF,
    parameter int unsigned       ID_W      = $clog2(N_CHAN),
    parameter logic [N_CHAN-1:0] EDGE_MODE = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CHAN-1:0] irq_in,
    input  logic              mask_we,
    input  logic [N_CHAN-1:0] mask_wdata,
    output logic              req_valid,
    output logic [ID_W-1:0]   req_id,
    input  logic              req_ready,
    input  logic              eoi,
    output logic              busy,
    output logic [N_CHAN-1:0] pending
);

    irq_state_e        r_state;
    logic [N_CHAN-1:0] r_pending;
    logic [N_CHAN-1:0] r_mask;
    logic [N_CHAN-1:0] r_hist;
    logic [ID_W-1:0]   r_req_id;
    logic              r_req_valid;
    logic              r_busy;

    logic [N_CHAN-1:0] w_set;
    logic [N_CHAN-1:0] w_clr;
    logic [N_CHAN-1:0] w_cand;
    logic              w_accept;
    logic              w_found;
    logic [ID_W-1:0]   w_sel;

    // Edge channels need a 0->1 against last cycle's sample; level channels
    // see their history bit forced to 0 by the mode mask.
    assign w_set    = irq_in & ~(r_hist & EDGE_MODE);
    assign w_accept = (r_state == OFFER) && req_ready;
    assign w_clr    = w_accept ? (N_CHAN'(1) << r_req_id) : '0;
    assign w_cand   = r_pending & ~r_mask;

    irq_prio_enc #(
        .N    (N_CHAN),
        .ID_W (ID_W)
    ) u_enc (
        .i_vec   (w_cand),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    // Input history for edge detection; cleared so a line high at release counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) r_hist <= '0;
        else     r_hist <= irq_in;
    end

    // Pending register: set has priority over the grant clear of the same bit.
    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~w_clr) | w_set;
    end

    // Mask register, all channels masked out of reset.
    always_ff @(posedge clk) begin
        if (rst)          r_mask <= '1;
        else if (mask_we) r_mask <= mask_wdata;
    end

    // Grant FSM with registered outputs; a ready in the same cycle as a mask
    // withdrawal still completes the transfer because req_valid was high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_id    <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_req_id    <= w_sel;
                        r_req_valid <= 1'b1;
                        r_state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SERVICE;
                    end else if (r_mask[r_req_id]) begin
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_valid = r_req_valid;
    assign req_id    = r_req_id;
    assign busy      = r_busy;
    assign pending   = r_pending;

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised, registered successor to the combinational 27-channel priority interrupt decoder. It latches requests from N_CHAN channels into a pending register, with per-channel edge or level capture and a per-channel mask. A fixed-priority encoder selects the lowest unmasked pending index and presents it to the CPU side on a valid/ready handshake. An in-service lock blocks further grants until end-of-interrupt (EOI).

## Interface
- N_CHAN, 27: number of request channels, 2..64.
- ID_W, $clog2(N_CHAN): width of the channel ID.
- EDGE_MODE, '1 (N_CHAN bits): per-channel capture mode; 1 = rising edge, 0 = level.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- irq_in  in  N_CHAN  raw request lines, already synchronous to clk.
- mask_we  in  1  load mask register this cycle.
- mask_wdata  in  N_CHAN  new mask; 1 = channel masked.
- req_valid  out  1  a grant is offered.
- req_id  out  ID_W  index of the granted channel; meaningful only when req_valid=1.
- req_ready  in  1  CPU accepts the grant.
- eoi  in  1  single-cycle end-of-interrupt pulse.
- busy  out  1  a grant has been accepted and its EOI has not yet arrived.
- pending  out  N_CHAN  current pending register; observability only.

## Operation
- Capture:
  - edge channel: set pending[i] when irq_in[i]=1 and its prior-cycle sample was 0.
  - level channel: set pending[i] whenever irq_in[i]=1.
  - Capture is independent of mask; masking gates selection only.
- Selection: sel = lowest i with pending[i] & ~mask[i]. Index 0 has the highest priority.
- FSM with three states:
  - IDLE: if any unmasked pending bit exists, register sel into req_id and go to OFFER.
  - OFFER: hold req_valid=1 with req_id stable. On req_ready=1, clear pending[req_id] and go to SERVICE.
  - SERVICE: busy=1. On eoi=1, go to IDLE.
- While in OFFER, req_id does not change, even if a higher-priority request arrives. The new request waits for the next IDLE evaluation.
- If the offered channel becomes masked while in OFFER, the grant is withdrawn: return to IDLE, and that pending bit stays set.
- Clear and set of the same pending bit in one cycle: set wins, so a new edge is not lost.
- eoi outside SERVICE is ignored. req_ready outside OFFER is ignored.
- A level channel still asserted after its clear re-pends on the next cycle.
- mask_we takes effect from the next cycle's selection.

## Timing
- Reset values:
  - req_valid=0, req_id=0, busy=0, pending=0, mask=all-ones (all channels masked).
  - Edge-detect history = 0, so a line that is high at reset release registers as an edge.
- Latency: irq_in edge at cycle t → pending set at t+1 → req_valid=1 at t+2 (FSM in IDLE, channel unmasked).
- Handshake: transfer occurs in the cycle where req_valid & req_ready are both 1. req_valid falls and busy rises in the next cycle.
- EOI: eoi at cycle t → busy=0 at t+1 → a new grant can appear at t+2.
- Reset mid-operation: any state returns to IDLE in the next cycle. All pending requests are discarded, and no grant is emitted in the reset cycle or the following one.

## Structure
- Shared package irq_pkg holds:
  - the state enum (IDLE, OFFER, SERVICE);
  - the default N_CHAN and ID_W constants;
  - the function prio_enc(vec) → {found, idx}.
- One sub-module, irq_prio_enc: parametrised combinational lowest-index encoder. It is reused by later multi-level controllers.
- The top-level module contains the capture logic, mask register and FSM.

## Test plan
- Reset, unmask all, pulse irq_in[5] high for 1 cycle → req_valid=1 with req_id=5 two cycles later; ready → busy=1, pending[5]=0.
- Pulse channels 3, 9 and 26 in the same cycle → grants in order 3, 9, 26, each issued only after its EOI.
- Mask channel 0, keep it pending, and pulse 7 → grant 7 with pending[0] still set. Unmask 0 after EOI → grant 0 next.
- Level channel 2 held high through accept+EOI → pending[2] re-sets and is re-granted. Edge channel 4 held high → granted once only.
- In OFFER with req_id=10, write mask bit 10 → req_valid drops the next cycle with pending[10]=1. Send eoi with busy=0 → no state change.
- Assert rst during SERVICE → all outputs are at their reset values the next cycle; no req_valid for 2 cycles after release, even with irq_in=all-ones.
